reg_dly_pipe: RTL and testbench

- Parametrised successor to the plain fixed-delay register chain.
- Each pipeline stage carries a valid bit alongside its data.
- Adds a global advance enable (stall), a synchronous flush, a run-time selectable output tap and an occupancy counter.
- Used wherever a side-band word must track a stallable datapath pipeline whose depth varies by mode (e.g. per-op latency alignment).

---
 rtl/reg_dly_pkg.sv | 14 +
 rtl/reg_dly_pipe_if.sv | 32 +++
 rtl/reg_dly_stage.sv | 41 ++++
 rtl/reg_dly_pipe.sv | 81 ++++++++
 tb/tb_reg_dly_pipe.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_dly_pkg.sv
// Shared constants and helpers for the valid-tracking stallable delay pipe.
package reg_dly_pkg;

  localparam int unsigned MAX_DLY_LIMIT = 64;

  // Elaboration-time ceil(log2(v)); returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/reg_dly_pipe_if.sv
// Bus bundle for reg_dly_pipe: advance/flush controls, input item, tap select
// and the tapped item plus occupancy status.
interface reg_dly_pipe_if
  import reg_dly_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned MAX_DLY = 4
) ();

  localparam int unsigned SEL_W = clog2(MAX_DLY + 1);

  logic             en;
  logic             flush;
  logic             d_vld;
  logic [WIDTH-1:0] d;
  logic [SEL_W-1:0] dly_sel;
  logic             q_vld;
  logic [WIDTH-1:0] q;
  logic [SEL_W-1:0] occ;
  logic             busy;

  modport master (
    output en, flush, d_vld, d, dly_sel,
    input  q_vld, q, occ, busy
  );

  modport slave (
    input  en, flush, d_vld, d, dly_sel,
    output q_vld, q, occ, busy
  );

endinterface

// File: rtl/reg_dly_stage.sv
// One {vld, data} pipeline stage. Data clear on rst/flush only exists when
// REG_DLY_DATA_RST_EN is defined; otherwise data is an unreset register.
module reg_dly_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             prev_vld,
  input  logic [WIDTH-1:0] prev_data,
  output logic             vld,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      vld <= 1'b0;
    end else if (en) begin
      vld <= prev_vld;
    end
  end

`ifdef REG_DLY_DATA_RST_EN
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      data <= '0;
    end else if (en) begin
      data <= prev_data;
    end
  end
`else
  // Flushed input must not land in the data register either.
  always_ff @(posedge clk) begin
    if (en && !flush) begin
      data <= prev_data;
    end
  end
`endif

endmodule

// File: rtl/reg_dly_pipe.sv
// Stallable, flushable delay chain with per-stage valid, run-time output tap
// and occupancy counter. Optional macro: REG_DLY_DATA_RST_EN (clear stage data).
module reg_dly_pipe
  import reg_dly_pkg::*;
#(
  parameter int unsigned WIDTH   = 1,
  parameter int unsigned MAX_DLY = 4
) (
  input logic           clk,
  input logic           rst,
  reg_dly_pipe_if.slave bus
);

  localparam int unsigned      SEL_W   = clog2(MAX_DLY + 1);
  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DLY);

  if (MAX_DLY < 1 || MAX_DLY > MAX_DLY_LIMIT) begin : g_bad_max_dly
    $error("reg_dly_pipe: MAX_DLY=%0d outside 1..%0d", MAX_DLY, MAX_DLY_LIMIT);
  end

  // Index 0 is the live input so the tap mux covers bypass uniformly.
  logic [MAX_DLY:0]            stage_vld;
  logic [MAX_DLY:0][WIDTH-1:0] stage_data;

  assign stage_vld[0]  = bus.d_vld;
  assign stage_data[0] = bus.d;

  for (genvar i = 1; i <= MAX_DLY; i++) begin : g_stage
    reg_dly_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .flush    (bus.flush),
      .prev_vld (stage_vld[i-1]),
      .prev_data(stage_data[i-1]),
      .vld      (stage_vld[i]),
      .data     (stage_data[i])
    );
  end

  // Tap select clamps to the last physical stage.
  logic [SEL_W-1:0] tap;

  always_comb begin
    tap = bus.dly_sel;
    if (bus.dly_sel > MAX_SEL) begin
      tap = MAX_SEL;
    end
  end

  assign bus.q_vld = stage_vld[tap];
  assign bus.q     = stage_data[tap];

  // Occupancy: +1 for a valid entering, -1 for a valid falling off the end.
  logic [SEL_W-1:0] occ_r;
  logic [SEL_W-1:0] occ_nxt;
  logic             busy_r;

  always_comb begin
    occ_nxt = occ_r;
    if (bus.en) begin
      occ_nxt = occ_r + SEL_W'(bus.d_vld) - SEL_W'(stage_vld[MAX_DLY]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      occ_r  <= '0;
      busy_r <= 1'b0;
    end else begin
      occ_r  <= occ_nxt;
      busy_r <= (occ_nxt != '0);
    end
  end

  assign bus.occ  = occ_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_reg_dly_pipe.sv
// Self-checking bench for reg_dly_pipe (WIDTH=8, MAX_DLY=4): directed scenarios
// then a randomized run against a history-queue reference model.
module tb_reg_dly_pipe;
  import reg_dly_pkg::*;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned MAX_DLY = 4;
  localparam int unsigned SEL_W   = clog2(MAX_DLY + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             flush;
  logic             d_vld;
  logic [WIDTH-1:0] d;
  logic [SEL_W-1:0] sel;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_dly_pipe_if #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY)) bus ();

  assign bus.en      = en;
  assign bus.flush   = flush;
  assign bus.d_vld   = d_vld;
  assign bus.d       = d;
  assign bus.dly_sel = sel;

  reg_dly_pipe #(.WIDTH(WIDTH), .MAX_DLY(MAX_DLY)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // hist[k-1] is what the k-th delay slot should hold (most recent first).
  typedef struct {
    logic             vld;
    logic [WIDTH-1:0] data;
    bit               known;
  } ent_t;

  ent_t hist[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    foreach (hist[i]) if (hist[i].vld) n++;
    return n;
  endfunction

  task automatic check_all(input string tag);
    int   s;
    ent_t e;
    s = (int'(sel) > int'(MAX_DLY)) ? int'(MAX_DLY) : int'(sel);
    chk({tag, ".occ"},  32'(bus.occ),  32'(model_occ()));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(model_occ() != 0));
    if (s == 0) begin
      chk({tag, ".byp_vld"}, 32'(bus.q_vld), 32'(d_vld));
      chk({tag, ".byp_q"},   32'(bus.q),     32'(d));
    end else begin
      e = hist[s-1];
      chk({tag, ".q_vld"}, 32'(bus.q_vld), 32'(e.vld));
      if (e.vld || e.known) chk({tag, ".q"}, 32'(bus.q), 32'(e.data));
    end
  endtask

  // Advance the model with the inputs currently applied, then cross one edge.
  task automatic tick();
    if (rst || flush) begin
      foreach (hist[i]) begin
        hist[i].vld = 1'b0;
`ifdef REG_DLY_DATA_RST_EN
        hist[i].data  = '0;
        hist[i].known = 1'b1;
`else
        hist[i].known = 1'b0;
`endif
      end
    end else if (en) begin
      hist.push_front(ent_t'{d_vld, d, 1'b1});
      void'(hist.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(MAX_DLY); i++) hist.push_back(ent_t'{1'b0, '0, 1'b0});
    rst = 1'b1; en = 1'b0; flush = 1'b0; d_vld = 1'b0; d = '0; sel = SEL_W'(1);
    #1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check_all("reset");
    chk("reset.occ0", 32'(bus.occ), 32'(0));
    chk("reset.qvld0", 32'(bus.q_vld), 32'(0));

    // Fixed latency through tap 3.
    sel = SEL_W'(3);
    en  = 1'b1;
    for (int n = 0; n < 8; n++) begin
      d_vld = (n < 3);
      d     = (n < 3) ? 8'(17 * (n + 1)) : 8'h00;
      #1;
      check_all($sformatf("lat%0d", n));
      if (n >= 3 && n <= 5) begin
        chk("lat.q_vld", 32'(bus.q_vld), 32'(1));
        chk("lat.q", 32'(bus.q), 32'(17 * (n - 2)));
      end
      if (n == 3) chk("lat.occ_peak", 32'(bus.occ), 32'(3));
      if (n == 7) chk("lat.occ_zero", 32'(bus.occ), 32'(0));
      tick();
    end

    // Stall: item enters, chain holds for three cycles, then resumes.
    sel = SEL_W'(2);
    for (int n = 0; n < 10; n++) begin
      en    = !(n >= 1 && n <= 3);
      d_vld = (n == 0);
      d     = (n == 0) ? 8'hA5 : 8'h00;
      #1;
      check_all($sformatf("stall%0d", n));
      chk("stall.q_vld", 32'(bus.q_vld), 32'(n == 5));
      if (n == 5) chk("stall.q", 32'(bus.q), 32'(8'hA5));
      if (n >= 1 && n <= 4) chk("stall.occ", 32'(bus.occ), 32'(1));
      tick();
    end

    // Flush a full pipe while a valid input is presented.
    sel = SEL_W'(4);
    en  = 1'b1;
    for (int n = 0; n < 4; n++) begin
      d_vld = 1'b1;
      d     = 8'(n + 1);
      #1;
      check_all("fill");
      tick();
    end
    #1;
    chk("flush.full", 32'(bus.occ), 32'(4));
    flush = 1'b1; d_vld = 1'b1; d = 8'h7E;
    tick();
    flush = 1'b0; d_vld = 1'b0; d = 8'h00;
    #1;
    chk("flush.occ", 32'(bus.occ), 32'(0));
    chk("flush.busy", 32'(bus.busy), 32'(0));
    for (int c = 0; c < 5; c++) begin
      for (int s = 1; s <= int'(MAX_DLY); s++) begin
        sel = SEL_W'(s);
        #1;
        chk($sformatf("flush.tap%0d", s), 32'(bus.q_vld), 32'(0));
        check_all("flush");
      end
      tick();
    end

    // Bypass is combinational and ignores en; oversize select clamps.
    sel = SEL_W'(0); d = 8'h3C; d_vld = 1'b1; en = 1'b0;
    #1;
    chk("byp.q_en0", 32'(bus.q), 32'(8'h3C));
    chk("byp.vld_en0", 32'(bus.q_vld), 32'(1));
    en = 1'b1;
    #1;
    chk("byp.q_en1", 32'(bus.q), 32'(8'h3C));
    for (int n = 0; n < 4; n++) begin
      d = 8'(8'h41 + n);
      #1;
      check_all("byp");
      tick();
    end
    d_vld = 1'b0;
    sel = SEL_W'(7);
    #1;
    chk("clamp.q", 32'(bus.q), 32'(8'h41));
    chk("clamp.vld", 32'(bus.q_vld), 32'(1));
    check_all("clamp");
    sel = SEL_W'(1);
    #1;
    chk("tap1.q", 32'(bus.q), 32'(8'h44));

    // Reset with items in flight discards everything.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int n = 0; n < 3; n++) begin
      d_vld = 1'b1;
      d     = 8'(8'h51 + n);
      tick();
    end
    #1;
    chk("rst.pre_occ", 32'(bus.occ), 32'(3));
    rst = 1'b1; en = 1'b1; d_vld = 1'b1; d = 8'h99;
    tick();
    rst = 1'b0; d_vld = 1'b0;
    #1;
    chk("rst.occ", 32'(bus.occ), 32'(0));
    chk("rst.busy", 32'(bus.busy), 32'(0));
    for (int s = 1; s <= int'(MAX_DLY); s++) begin
      sel = SEL_W'(s);
      #1;
      chk($sformatf("rst.vld%0d", s), 32'(bus.q_vld), 32'(0));
`ifdef REG_DLY_DATA_RST_EN
      chk($sformatf("rst.q%0d", s), 32'(bus.q), 32'(0));
`endif
    end
    tick();

    // Randomized regression at a fixed tap.
    sel = SEL_W'(3);
    for (int i = 0; i < 10000; i++) begin
      en    = ($urandom_range(0, 3) != 0);
      d_vld = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 31) == 0);
      rst   = ($urandom_range(0, 99) == 0);
      d     = 8'($urandom);
      #1;
      check_all("rnd");
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
